// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: WB always wins, long-latency results queue in a
// small FIFO that drains on idle WB cycles, with a starvation bubble and pending mask.
module rf_wport_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_waddr,
    input  logic [31:0] wb_wdata,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_waddr,
    input  logic [31:0] lu_wdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        wb_hold,
    output logic [31:0] pend_mask,
    output logic        proto_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [3:0] CNT_LAST = 4'(STARVE_LIMIT - 1);

    typedef enum logic {RUN, HOLD} state_e;

    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [4:0]       addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] live_q;
    state_e           state_q;
    logic [3:0]       starve_cnt_q;
    logic             proto_err_q;

    logic [AW-1:0] wr_idx, rd_idx;
    logic          empty, full, push, pop, push_killed;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

    // lu_ready is a pure function of the stored occupancy, never of this cycle's pop.
    assign lu_ready    = !full;
    assign push        = !reset && lu_valid && !full && (lu_waddr != 5'd0);
    assign pop         = !reset && !wb_we && !empty;
    assign push_killed = wb_we && (wb_waddr == lu_waddr);

    assign wb_hold   = (state_q == HOLD);
    assign proto_err = proto_err_q;

    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (!reset) begin
            if (wb_we) begin
                rf_we    = 1'b1;
                rf_waddr = wb_waddr;
                rf_wdata = wb_wdata;
            end else if (!empty) begin
                rf_we    = live_q[rd_idx];
                rf_waddr = addr_q[rd_idx];
                rf_wdata = data_q[rd_idx];
            end
        end
    end

    always_comb begin
        pend_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) pend_mask[addr_q[i]] = 1'b1;
        end
    end

    // NOTE: only pointers and live bits are reset; payload storage is qualified by live_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            live_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments; later writes to the same bit win.
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_we && live_q[i] && (addr_q[i] == wb_waddr)) live_q[i] <= 1'b0;
            end
            if (pop) begin
                live_q[rd_idx] <= 1'b0;
                rd_ptr_q       <= rd_ptr_q + 1'b1;
            end
            if (push) begin
                addr_q[wr_idx] <= lu_waddr;
                data_q[wr_idx] <= lu_wdata;
                live_q[wr_idx] <= !push_killed;
                wr_ptr_q       <= wr_ptr_q + 1'b1;
            end
        end
    end

    // Starvation FSM: one forced WB bubble after the head has waited STARVE_LIMIT cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            starve_cnt_q <= 4'd0;
            proto_err_q  <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (pop || empty) begin
                        starve_cnt_q <= 4'd0;
                    end else if (starve_cnt_q == CNT_LAST) begin
                        state_q <= HOLD;
                    end else begin
                        starve_cnt_q <= starve_cnt_q + 4'd1;
                    end
                end
                HOLD: begin
                    state_q <= RUN;
                    if (wb_we) proto_err_q  <= 1'b1;
                    else       starve_cnt_q <= 4'd0;
                end
                default: state_q <= RUN;
            endcase
        end
    end

endmodule
